// File: rtl/io_edge_capture.sv
// Synchronises an io bus, detects masked per-bit edges and queues each qualifying
// change as a timestamped {lost, ts, level} event on a valid/ready stream.
module io_edge_capture #(
  parameter int WIDTH       = 1,
  parameter int TS_WIDTH    = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          io_in,
  input  logic                      enable,
  input  logic [WIDTH-1:0]          rise_en,
  input  logic [WIDTH-1:0]          fall_en,
  output logic [WIDTH-1:0]          level,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [WIDTH+TS_WIDTH:0]   m_data,
  output logic [15:0]               drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = WIDTH + TS_WIDTH + 1;

  logic [WIDTH-1:0]       sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] fill;
  logic                   fill_done;
  logic [WIDTH-1:0]       prev;
  logic                   primed;
  logic [TS_WIDTH-1:0]    ts;
  logic                   lost;
  logic [DW-1:0]          mem [FIFO_DEPTH];
  logic [AW:0]            wr_ptr;
  logic [AW:0]            rd_ptr;
  logic                   empty;
  logic                   full;
  logic                   hit;
  logic                   pop;
  logic                   push;
  logic                   drop;
  logic [WIDTH-1:0]       rise;
  logic [WIDTH-1:0]       fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      fill <= '0;
    end else begin
      sync_q[0] <= io_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      fill <= {fill[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign level     = sync_q[SYNC_STAGES-1];
  // level only reflects a real io sample once the whole chain has been refilled
  // after reset; priming before that would compare against the reset zeros.
  assign fill_done = fill[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      prev   <= '0;
      primed <= 1'b0;
      ts     <= '0;
    end else if (enable) begin
      prev   <= level;
      primed <= fill_done;
      ts     <= ts + TS_WIDTH'(1);
    end else begin
      primed <= 1'b0;
      ts     <= '0;
    end
  end

  assign rise  = level & ~prev;
  assign fall  = ~level & prev;
  assign hit   = enable & primed & (|((rise & rise_en) | (fall & fall_en)));

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = ~empty & m_ready;
  assign push  = hit & (~full | pop);
  assign drop  = hit & full & ~pop;

  // On a full FIFO with a same-cycle pop the write lands in the slot being vacated.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {lost, ts, level};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      lost       <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push) begin
        lost <= 1'b0;
      end else if (drop) begin
        lost <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
    end
  end

  assign m_valid = ~empty;
  assign m_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_io_edge_capture.sv
// Bench for io_edge_capture: directed vector table, corner-case sequences and a
// randomized run checked against a queue-based reference model.
module tb_io_edge_capture;

  localparam int W     = 4;
  localparam int TSW   = 8;
  localparam int DEPTH = 8;
  localparam int SYNC  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  io_in;
  logic          enable;
  logic [W-1:0]  rise_en;
  logic [W-1:0]  fall_en;
  logic [W-1:0]  level;
  logic          m_valid;
  logic          m_ready;
  logic [12:0]   m_data;
  logic [15:0]   drop_count;

  int checks   = 0;
  int failures = 0;

  io_edge_capture #(
    .WIDTH(W), .TS_WIDTH(TSW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .reset(reset), .io_in(io_in), .enable(enable),
    .rise_en(rise_en), .fall_en(fall_en), .level(level),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Reference model: the synchroniser is a queue of past samples (front = level),
  // the event FIFO is a queue of packed events.
  logic [W-1:0]  ref_sync[$];
  logic [12:0]   ref_fifo[$];
  logic [W-1:0]  ref_prev;
  bit            ref_primed;
  bit            ref_lost;
  int            ref_ts;
  int            ref_drops;
  int            ref_since_reset;
  logic [12:0]   popped[$];

  task automatic check_eq(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic ref_reset();
    ref_sync.delete();
    for (int i = 0; i < SYNC; i++) ref_sync.push_back('0);
    ref_fifo.delete();
    ref_prev        = '0;
    ref_primed      = 1'b0;
    ref_lost        = 1'b0;
    ref_ts          = 0;
    ref_drops       = 0;
    ref_since_reset = 0;
  endtask

  task automatic model_step();
    logic [W-1:0] lvl;
    bit was_full, pop, hit;
    if (reset) begin
      ref_reset();
      return;
    end
    lvl      = ref_sync[0];
    was_full = (ref_fifo.size() == DEPTH);
    pop      = (ref_fifo.size() != 0) && m_ready;
    hit      = enable && ref_primed &&
               (((lvl & ~ref_prev & rise_en) | (~lvl & ref_prev & fall_en)) != '0);
    if (pop) void'(ref_fifo.pop_front());
    if (hit) begin
      if (!was_full || pop) begin
        ref_fifo.push_back({ref_lost, 8'(ref_ts), lvl});
        ref_lost = 1'b0;
      end else begin
        if (ref_drops < 65535) ref_drops++;
        ref_lost = 1'b1;
      end
    end
    if (enable) begin
      ref_prev   = lvl;
      ref_primed = (ref_since_reset >= SYNC);
      ref_ts     = (ref_ts + 1) % 256;
    end else begin
      ref_primed = 1'b0;
      ref_ts     = 0;
    end
    void'(ref_sync.pop_front());
    ref_sync.push_back(io_in);
    ref_since_reset++;
  endtask

  task automatic checkOutput();
    check_eq("level", 32'(level), 32'(ref_sync[0]));
    check_eq("m_valid", 32'(m_valid), 32'(ref_fifo.size() != 0));
    check_eq("m_data", 32'(m_data), (ref_fifo.size() != 0) ? 32'(ref_fifo[0]) : 32'h0);
    check_eq("drop_count", 32'(drop_count), 32'(ref_drops));
  endtask

  task automatic tick();
    model_step();
    if (!reset && m_valid && m_ready) popped.push_back(m_data);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(logic rst, logic [W-1:0] io, logic en,
                               logic [W-1:0] re, logic [W-1:0] fe, logic rdy);
    reset   = rst;
    io_in   = io;
    enable  = en;
    rise_en = re;
    fall_en = fe;
    m_ready = rdy;
  endtask

  typedef struct {
    logic         rst;
    logic [W-1:0] io;
    logic         en;
    logic [W-1:0] re;
    logic [W-1:0] fe;
    logic         rdy;
    logic [W-1:0] e_level;
    logic         e_valid;
    logic [12:0]  e_data;
  } vec_t;

  vec_t vec_tab[15];

  initial begin
    ref_reset();
    applyStimulus(1'b1, 4'h0, 1'b1, 4'h1, 4'h0, 1'b0);

    vec_tab[0]  = '{1'b1, 4'h0, 1'b1, 4'h1, 4'h0, 1'b0, 4'h0, 1'b0, 13'h000};
    vec_tab[1]  = '{1'b0, 4'h0, 1'b1, 4'h1, 4'h0, 1'b0, 4'h0, 1'b0, 13'h000};
    vec_tab[2]  = '{1'b0, 4'h1, 1'b1, 4'h1, 4'h0, 1'b0, 4'h0, 1'b0, 13'h000};
    vec_tab[3]  = '{1'b0, 4'h1, 1'b1, 4'h1, 4'h0, 1'b0, 4'h1, 1'b0, 13'h000};
    vec_tab[4]  = '{1'b0, 4'h1, 1'b1, 4'h1, 4'h0, 1'b0, 4'h1, 1'b1, 13'h031};
    vec_tab[5]  = '{1'b0, 4'h0, 1'b1, 4'h1, 4'h0, 1'b0, 4'h1, 1'b1, 13'h031};
    vec_tab[6]  = '{1'b0, 4'h0, 1'b1, 4'h1, 4'h0, 1'b1, 4'h0, 1'b0, 13'h000};
    vec_tab[7]  = '{1'b0, 4'h0, 1'b1, 4'h1, 4'h0, 1'b1, 4'h0, 1'b0, 13'h000};
    vec_tab[8]  = '{1'b0, 4'h2, 1'b1, 4'h1, 4'h0, 1'b1, 4'h0, 1'b0, 13'h000};
    vec_tab[9]  = '{1'b0, 4'h2, 1'b1, 4'h1, 4'h0, 1'b1, 4'h2, 1'b0, 13'h000};
    vec_tab[10] = '{1'b0, 4'h2, 1'b1, 4'h1, 4'h0, 1'b1, 4'h2, 1'b0, 13'h000};
    vec_tab[11] = '{1'b0, 4'h5, 1'b1, 4'hF, 4'hF, 1'b0, 4'h2, 1'b0, 13'h000};
    vec_tab[12] = '{1'b0, 4'h5, 1'b1, 4'hF, 4'hF, 1'b0, 4'h5, 1'b0, 13'h000};
    vec_tab[13] = '{1'b0, 4'h5, 1'b1, 4'hF, 4'hF, 1'b0, 4'h5, 1'b1, 13'h0C5};
    vec_tab[14] = '{1'b0, 4'h5, 1'b1, 4'hF, 4'hF, 1'b1, 4'h5, 1'b0, 13'h000};

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vec_tab[i].rst, vec_tab[i].io, vec_tab[i].en,
                    vec_tab[i].re, vec_tab[i].fe, vec_tab[i].rdy);
      tick();
      check_eq($sformatf("vec%0d_level", i), 32'(level), 32'(vec_tab[i].e_level));
      check_eq($sformatf("vec%0d_valid", i), 32'(m_valid), 32'(vec_tab[i].e_valid));
      check_eq($sformatf("vec%0d_data", i), 32'(m_data), 32'(vec_tab[i].e_data));
      check_eq($sformatf("vec%0d_drop", i), 32'(drop_count), 32'h0);
    end

    // Bus idling high through reset must not look like a rising edge.
    applyStimulus(1'b1, 4'hF, 1'b1, 4'hF, 4'hF, 1'b0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 1) check_eq("idle_high_level", 32'(level), 32'hF);
      check_eq("idle_high_no_event", 32'(m_valid), 32'h0);
    end

    // Overflow: ten edges into an eight-deep FIFO with the sink stalled.
    applyStimulus(1'b1, 4'h0, 1'b1, 4'h1, 4'h0, 1'b0);
    tick();
    reset = 1'b0;
    repeat (4) tick();
    for (int k = 0; k < 10; k++) begin
      io_in = 4'h1; tick(); tick();
      io_in = 4'h0; tick(); tick();
    end
    repeat (4) tick();
    check_eq("overflow_drops", 32'(drop_count), 32'd2);
    check_eq("overflow_valid", 32'(m_valid), 32'h1);

    // Push and pop on the same edge while full.
    popped.delete();
    io_in = 4'h1; tick(); tick();
    m_ready = 1'b1; tick();
    m_ready = 1'b0;
    check_eq("full_pushpop_drops", 32'(drop_count), 32'd2);
    check_eq("full_pushpop_valid", 32'(m_valid), 32'h1);
    io_in = 4'h0;
    m_ready = 1'b1;
    repeat (12) tick();
    io_in = 4'h1; repeat (4) tick();
    io_in = 4'h0; repeat (4) tick();
    check_eq("drain_count", 32'(popped.size()), 32'd10);
    if (popped.size() == 10) begin
      for (int i = 0; i < 10; i++)
        check_eq($sformatf("drain%0d_lost", i), 32'(popped[i][12]), (i == 8) ? 32'h1 : 32'h0);
    end

    // Reset with events queued discards them and clears the drop counter.
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      io_in = 4'h1; tick(); tick();
      io_in = 4'h0; tick(); tick();
    end
    repeat (3) tick();
    check_eq("queued_before_reset", 32'(m_valid), 32'h1);
    reset = 1'b1; tick();
    reset = 1'b0;
    check_eq("reset_flush_valid", 32'(m_valid), 32'h0);
    check_eq("reset_flush_drops", 32'(drop_count), 32'h0);

    // Timestamps of edges 300 cycles apart differ by 300 mod 256.
    applyStimulus(1'b0, 4'h0, 1'b1, 4'h1, 4'h0, 1'b1);
    repeat (4) tick();
    popped.delete();
    io_in = 4'h1; repeat (5) tick();
    io_in = 4'h0; repeat (295) tick();
    io_in = 4'h1; repeat (5) tick();
    io_in = 4'h0; repeat (5) tick();
    check_eq("ts_wrap_events", 32'(popped.size()), 32'd2);
    if (popped.size() == 2)
      check_eq("ts_wrap_delta", 32'((popped[1][11:4] - popped[0][11:4]) & 8'hFF), 32'd44);

    // Disabled: edges ignored, ts restarts from 0 after re-enable.
    applyStimulus(1'b0, 4'h0, 1'b0, 4'h1, 4'h0, 1'b0);
    repeat (5) tick();
    io_in = 4'h1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("disabled_no_event", 32'(m_valid), 32'h0);
    end
    enable = 1'b1;
    repeat (3) tick();
    io_in = 4'h0; repeat (3) tick();
    io_in = 4'h1; repeat (3) tick();
    check_eq("reenable_valid", 32'(m_valid), 32'h1);
    check_eq("reenable_event", 32'(m_data), 32'h081);

    // Randomized run against the reference model.
    applyStimulus(1'b1, 4'h0, 1'b1, 4'hF, 4'hF, 1'b0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) io_in = io_in ^ 4'($urandom_range(1, 15));
      enable = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 99) == 0) rise_en = 4'($urandom);
      if ($urandom_range(0, 99) == 0) fall_en = 4'($urandom);
      if (((c / 200) % 2) == 0) m_ready = ($urandom_range(0, 7) == 0);
      else                      m_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 599) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
